// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard receive path:
// FSM states, frame geometry, common scan codes and a frame check helper.
package ps2_kbd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int PS2_FRAME_BITS = 11;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // Frame layout once fully shifted in: [0]=start, [8:1]=data,
   // [9]=parity, [10]=stop. Good frame: start low, odd parity, stop high.
   function automatic logic frame_ok(input logic [10:0] f);
      return ~f[0] & (^f[9:1]) & f[10];
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO: push/full write side, valid/ready read side,
// head word presented combinationally from the storage registers.
module ps2_rx_fifo
   import ps2_kbd_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_full,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   input  logic             i_ready
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;

   logic w_pop;
   logic w_wr;

   assign o_valid = (r_cnt != '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_pop   = o_valid & i_ready;
   assign w_wr    = i_push & (~o_full | w_pop);
   assign o_dout  = o_valid ? r_mem[r_rd] : '0;

   // Storage write; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr] <= i_din;
      end
   end

   // Pointers wrap naturally; the count decides full/empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         unique case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: pin sync, falling-edge detect, frame FSM,
// mid-frame timeout, sticky error flags and a scan-code FIFO.
module ps2_kbd_ctrl
   import ps2_kbd_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       frame_err,
   output logic       overflow,
   input  logic       clr_flags
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [2:0]    r_clk_s;
   logic [1:0]    r_data_s;
   logic [10:0]   r_shift;
   logic [3:0]    r_bitcnt;
   logic [TW-1:0] r_idle;
   logic          r_frame_err;
   logic          r_overflow;

   logic w_fall;
   logic w_bit;
   logic w_timeout;
   logic w_done;
   logic w_good;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_err_set;
   logic w_ovf_set;

   assign w_fall    = r_clk_s[2] & ~r_clk_s[1];
   assign w_bit     = r_data_s[1];
   assign w_timeout = (r_idle == TO_LAST);
   assign w_done    = (r_state == ST_DONE);
   assign w_good    = frame_ok(r_shift);
   assign w_pop     = code_valid & code_ready;
   assign w_push    = w_done & w_good & (~w_full | w_pop);
   assign w_ovf_set = w_done & w_good & w_full & ~w_pop;
   assign w_err_set = w_done & ~w_good;

   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

   // Two-flop data and three-flop clock synchronisers, idle-high on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_s  <= 3'b111;
         r_data_s <= 2'b11;
      end else begin
         r_clk_s  <= {r_clk_s[1:0], ps2_clk};
         r_data_s <= {r_data_s[0], ps2_data};
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: a fall wins over a coincident timeout in RECV.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               w_state_nxt = ST_RECV;
            end
         end
         ST_RECV: begin
            if (w_fall) begin
               if (r_bitcnt == LAST_BIT) begin
                  w_state_nxt = ST_DONE;
               end
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift register, bit counter and mid-frame idle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_idle   <= '0;
      end else begin
         if (w_fall && (r_state != ST_DONE)) begin
            r_shift <= {w_bit, r_shift[10:1]};
         end
         unique case (r_state)
            ST_IDLE: begin
               r_bitcnt <= w_fall ? 4'd1 : 4'd0;
               r_idle   <= '0;
            end
            ST_RECV: begin
               if (w_fall) begin
                  r_bitcnt <= r_bitcnt + 4'd1;
                  r_idle   <= '0;
               end else if (w_timeout) begin
                  r_bitcnt <= '0;
                  r_idle   <= '0;
               end else begin
                  r_idle <= r_idle + 1'b1;
               end
            end
            default: begin
               r_bitcnt <= '0;
               r_idle   <= '0;
            end
         endcase
      end
   end

   // Sticky flags; a new event in the clear cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_err_set) begin
            r_frame_err <= 1'b1;
         end else if (clr_flags) begin
            r_frame_err <= 1'b0;
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (clr_flags) begin
            r_overflow <= 1'b0;
         end
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (r_shift[8:1]),
      .o_full  (w_full),
      .o_dout  (code),
      .o_valid (code_valid),
      .i_ready (code_ready)
   );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: bit-level PS/2 keyboard model, frame-level
// reference queue, vector table, directed corner cases, random frames.
module tb_ps2_kbd_ctrl;
   import ps2_kbd_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] code;
   logic       code_valid;
   logic       code_ready = 1'b0;
   logic       frame_err;
   logic       overflow;
   logic       clr_flags = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic       m_err = 1'b0;
   logic       m_ovf = 1'b0;

   ps2_kbd_ctrl #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (512)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .clr_flags  (clr_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One PS/2 bit: data changes mid-high, then a 50-cycle low phase.
   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(25);
      ps2_clk = 1'b0;
      tick(50);
      ps2_clk = 1'b1;
      tick(25);
   endtask

   task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send_bit(f[i]);
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d,
      input logic st, input logic pflip, input logic sp);
      logic par;
      par = ~(^d) ^ pflip;
      return {sp, par, d, st};
   endfunction

   // Frame-level reference: count ones over data+parity, queue or flag.
   task automatic model_frame(input logic [10:0] f);
      int ones;
      ones = 0;
      for (int i = 1; i <= 9; i++) ones += int'(f[i]);
      if (f[0] == 1'b0 && (ones % 2) == 1 && f[10] == 1'b1) begin
         if (mq.size() < 8) mq.push_back(f[8:1]);
         else m_ovf = 1'b1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic frame(input logic [10:0] f);
      send_bits(f, 0, 10);
      tick(20);
      model_frame(f);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 32'(code_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk({tag, ".code"}, 32'(code), 32'(mq[0]));
      chk({tag, ".err"}, 32'(frame_err), 32'(m_err));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
   endtask

   task automatic pop_one(input string tag);
      chk({tag, ".pop_valid"}, 32'(code_valid), 32'd1);
      if (mq.size() != 0) begin
         chk({tag, ".pop_code"}, 32'(code), 32'(mq[0]));
         void'(mq.pop_front());
      end
      code_ready = 1'b1;
      tick(1);
      code_ready = 1'b0;
   endtask

   task automatic clr();
      clr_flags = 1'b1;
      tick(1);
      clr_flags = 1'b0;
      m_err = 1'b0;
      m_ovf = 1'b0;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       st;
      logic       pf;
      logic       sp;
      logic       e_valid;
      logic [7:0] e_code;
      logic       e_err;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [10:0] f;
      int np;
      tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0};
      tbl[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
      tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[4] = '{SC_BREAK, 1'b0, 1'b0, 1'b1, 1'b1, SC_BREAK, 1'b0};
      tbl[5] = '{SC_EXT, 1'b0, 1'b0, 1'b1, 1'b1, SC_EXT, 1'b0};

      tick(3);
      chk("rst.valid", 32'(code_valid), 32'd0);
      chk("rst.code", 32'(code), 32'd0);
      chk("rst.err", 32'(frame_err), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick(5);

      for (int i = 0; i < 6; i++) begin
         f = mk_frame(tbl[i].d, tbl[i].st, tbl[i].pf, tbl[i].sp);
         frame(f);
         chk($sformatf("tbl%0d.valid", i), 32'(code_valid),
             32'(tbl[i].e_valid));
         if (tbl[i].e_valid)
            chk($sformatf("tbl%0d.code", i), 32'(code), 32'(tbl[i].e_code));
         chk($sformatf("tbl%0d.err", i), 32'(frame_err), 32'(tbl[i].e_err));
         chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'd0);
         if (tbl[i].e_valid) begin
            pop_one($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.empty", i), 32'(code_valid), 32'd0);
         end
         if (tbl[i].e_err) begin
            clr();
            chk($sformatf("tbl%0d.clr", i), 32'(frame_err), 32'd0);
         end
      end

      frame(mk_frame(8'hF0, 1'b0, 1'b0, 1'b1));
      frame(mk_frame(8'h1C, 1'b0, 1'b0, 1'b1));
      check_model("ord");
      chk("ord.first", 32'(code), 32'h00F0);
      pop_one("ord0");
      chk("ord.second", 32'(code), 32'h001C);
      pop_one("ord1");
      check_model("ord.end");

      for (int i = 1; i <= 9; i++) frame(mk_frame(8'(i), 1'b0, 1'b0, 1'b1));
      chk("ovf.flag", 32'(overflow), 32'd1);
      check_model("ovf");
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("ovf.code%0d", i), 32'(code), 32'(i));
         pop_one("ovf");
      end
      chk("ovf.empty", 32'(code_valid), 32'd0);
      clr();
      chk("ovf.clr", 32'(overflow), 32'd0);

      f = mk_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      send_bits(f, 0, 4);
      tick(600);
      frame(mk_frame(8'h5A, 1'b0, 1'b0, 1'b1));
      chk("to.code", 32'(code), 32'h005A);
      chk("to.err", 32'(frame_err), 32'd0);
      check_model("to");
      pop_one("to");

      frame(mk_frame(8'h11, 1'b0, 1'b0, 1'b1));
      frame(mk_frame(8'h22, 1'b0, 1'b0, 1'b1));
      frame(mk_frame(8'h33, 1'b0, 1'b1, 1'b1));
      check_model("pre_rst");
      f = mk_frame(8'h66, 1'b0, 1'b0, 1'b1);
      send_bits(f, 0, 3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      mq.delete();
      m_err = 1'b0;
      m_ovf = 1'b0;
      chk("rst6.valid", 32'(code_valid), 32'd0);
      chk("rst6.err", 32'(frame_err), 32'd0);
      chk("rst6.ovf", 32'(overflow), 32'd0);
      send_bits(f, 4, 10);
      tick(600);
      frame(mk_frame(8'h29, 1'b0, 1'b0, 1'b1));
      chk("rst6.code", 32'(code), 32'h0029);
      check_model("rst6");
      pop_one("rst6");

      for (int i = 0; i < 10; i++) begin
         int kind;
         logic [7:0] d;
         d = 8'($urandom);
         kind = $urandom_range(0, 5);
         f = mk_frame(d, kind == 1, kind == 0, kind != 2);
         frame(f);
         check_model($sformatf("rnd%0d", i));
         np = $urandom_range(0, mq.size() / 2);
         for (int j = 0; j < np; j++) pop_one($sformatf("rnd%0d", i));
         if ($urandom_range(0, 3) == 0) clr();
         check_model($sformatf("rnd%0d.post", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
